// File: rtl/axi_mem_perf_uart.sv
// AXI4 memory throughput tester: burst write/readback against an internal slave, UART result line.
// Optional: define AXI_MEM_PERF_ERR_INJECT_EN to corrupt bit0 of the first written beat.
module axi_mem_perf_uart #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned NUM_BURSTS = 16
) (
  input  logic clk,
  input  logic rst,
  output logic utx_pin,
  input  logic urx_pin
);

  localparam int unsigned BIT_CLKS = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned DEPTH    = BURST_LEN * NUM_BURSTS;
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ADDR_W   = IDX_W + 2;

  typedef enum logic [2:0] {
    ST_START, ST_WR_ADDR, ST_WR_DATA, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA, ST_REPORT, ST_DONE
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [7:0]            beat;
  logic [15:0]           burst;
  logic [31:0]           wr_cycles, rd_cycles;
  logic [15:0]           err_cnt;
  logic                  last_burst;

  logic                  awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic                  arvalid, arready, rvalid, rready, rlast;
  logic [ADDR_W-1:0]     awaddr, araddr;
  logic [7:0]            arlen;
  logic [DATA_WIDTH-1:0] wdata, rdata;

  logic                  s_wbusy;
  logic [IDX_W-1:0]      s_wptr, s_rptr;
  logic [7:0]            s_rcnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  tx_active;
  logic [8:0]            tx_sh;
  logic [3:0]            tx_bitn;
  logic [31:0]           tx_baud;
  logic [4:0]            tx_byte, char_idx;
  logic [7:0]            tx_char;
  logic [3:0]            nib;

  logic                  rx_s1, rx_s2, rx_busy, rx_done;
  logic [31:0]           rx_cnt;
  logic [3:0]            rx_bitn;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [IDX_W-1:0] i);
    return DATA_WIDTH'({16'hA5A5, 16'(i)});
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
  endfunction

  assign last_burst = (burst == 16'(NUM_BURSTS - 1));
  assign wlast      = (beat == 8'(BURST_LEN - 1));
  assign awaddr     = {wr_idx, 2'b00};
  assign araddr     = {rd_idx, 2'b00};
  assign arlen      = 8'(BURST_LEN - 1);
  assign bready     = 1'b1;
  assign rready     = 1'b1;
`ifdef AXI_MEM_PERF_ERR_INJECT_EN
  assign wdata      = pattern(wr_idx) ^ DATA_WIDTH'(wr_idx == '0);
`else
  assign wdata      = pattern(wr_idx);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_START;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    arvalid  = 1'b0;
    case (state)
      ST_START:   state_nx = ST_WR_ADDR;
      ST_WR_ADDR: begin
        awvalid = 1'b1;
        if (awready) state_nx = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        wvalid = 1'b1;
        if (wready && wlast) state_nx = ST_WR_RESP;
      end
      ST_WR_RESP: if (bvalid) state_nx = last_burst ? ST_RD_ADDR : ST_WR_ADDR;
      ST_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nx = ST_RD_DATA;
      end
      ST_RD_DATA: if (rvalid && rlast) state_nx = last_burst ? ST_REPORT : ST_RD_ADDR;
      ST_REPORT:  if (tx_byte == 5'd30) state_nx = ST_DONE;
      ST_DONE:    if (rx_done) state_nx = ST_START;
      default:    state_nx = ST_START;
    endcase
  end

  // Traffic generator bookkeeping and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst || state == ST_START) begin
      wr_idx <= '0; rd_idx <= '0; beat <= '0; burst <= '0;
      wr_cycles <= '0; rd_cycles <= '0; err_cnt <= '0;
    end else begin
      if ((state == ST_WR_ADDR || state == ST_WR_DATA || state == ST_WR_RESP) && wr_cycles != '1)
        wr_cycles <= wr_cycles + 32'd1;
      if ((state == ST_RD_ADDR || state == ST_RD_DATA) && rd_cycles != '1)
        rd_cycles <= rd_cycles + 32'd1;
      if (wvalid && wready) begin
        wr_idx <= wr_idx + 1'b1;
        beat   <= wlast ? 8'd0 : beat + 8'd1;
      end
      if (state == ST_WR_RESP && bvalid && bready)
        burst <= last_burst ? 16'd0 : burst + 16'd1;
      if (state == ST_RD_DATA && rvalid && rready) begin
        rd_idx <= rd_idx + 1'b1;
        if (rdata != pattern(rd_idx) && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
        if (rlast) burst <= last_burst ? 16'd0 : burst + 16'd1;
      end
    end
  end

  // Memory slave: ready whenever idle, back-to-back read beats, B one cycle after WLAST
  assign awready = !s_wbusy && !bvalid && !rvalid;
  assign arready = !s_wbusy && !bvalid && !rvalid;
  assign wready  = s_wbusy;
  assign rlast   = rvalid && (s_rcnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_wbusy <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      s_wptr <= '0; s_rptr <= '0; s_rcnt <= '0; rdata <= '0;
    end else begin
      if (awvalid && awready) begin
        s_wbusy <= 1'b1;
        s_wptr  <= IDX_W'(awaddr >> 2);
      end
      if (wvalid && wready) begin
        s_wptr <= s_wptr + 1'b1;
        if (wlast) begin
          s_wbusy <= 1'b0;
          bvalid  <= 1'b1;
        end
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        s_rcnt <= arlen;
        rdata  <= mem[IDX_W'(araddr >> 2)];
        s_rptr <= IDX_W'(araddr >> 2) + 1'b1;
      end else if (rvalid && rready) begin
        if (rlast) rvalid <= 1'b0;
        else begin
          rdata  <= mem[s_rptr];
          s_rptr <= s_rptr + 1'b1;
          s_rcnt <= s_rcnt - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wvalid && wready) mem[s_wptr] <= wdata;
  end

  // Report text: "W=%08X R=%08X E=%04X\r\n"; next char is preloaded so frames chain without gaps
  assign char_idx = tx_active ? tx_byte + 5'd1 : tx_byte;

  always_comb begin
    nib     = 4'h0;
    tx_char = 8'h20;
    case (char_idx)
      5'd0:                tx_char = "W";
      5'd1, 5'd12, 5'd23:  tx_char = "=";
      5'd10, 5'd21:        tx_char = " ";
      5'd11:               tx_char = "R";
      5'd22:               tx_char = "E";
      5'd28:               tx_char = 8'h0D;
      5'd29:               tx_char = 8'h0A;
      default: begin
        if (char_idx <= 5'd9)       nib = 4'(wr_cycles >> (32'd4 * (32'd9 - 32'(char_idx))));
        else if (char_idx <= 5'd20) nib = 4'(rd_cycles >> (32'd4 * (32'd20 - 32'(char_idx))));
        else if (char_idx <= 5'd27) nib = 4'(err_cnt >> (32'd4 * (32'd27 - 32'(char_idx))));
        tx_char = hex_char(nib);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state == ST_START) begin
      utx_pin <= 1'b1; tx_active <= 1'b0; tx_sh <= '1;
      tx_bitn <= '0; tx_baud <= '0; tx_byte <= '0;
    end else if (state == ST_REPORT) begin
      if (!tx_active) begin
        if (tx_byte != 5'd30) begin
          utx_pin <= 1'b0; tx_sh <= {1'b1, tx_char};
          tx_bitn <= '0; tx_baud <= '0; tx_active <= 1'b1;
        end
      end else if (tx_baud == 32'(BIT_CLKS - 1)) begin
        tx_baud <= '0;
        if (tx_bitn == 4'd9) begin
          tx_byte <= tx_byte + 5'd1;
          if (tx_byte == 5'd29) begin
            tx_active <= 1'b0;
            utx_pin   <= 1'b1;
          end else begin
            utx_pin <= 1'b0; tx_sh <= {1'b1, tx_char}; tx_bitn <= '0;
          end
        end else begin
          utx_pin <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
          tx_bitn <= tx_bitn + 4'd1;
        end
      end else begin
        tx_baud <= tx_baud + 32'd1;
      end
    end
  end

  // Receiver only needs frame completion; first sample lands mid data bit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_busy <= 1'b0; rx_done <= 1'b0;
      rx_cnt <= '0; rx_bitn <= '0;
    end else begin
      rx_s1   <= urx_pin;
      rx_s2   <= rx_s1;
      rx_done <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= 32'(BIT_CLKS + BIT_CLKS / 2 - 1);
          rx_bitn <= '0;
        end
      end else if (rx_cnt != 32'd0) begin
        rx_cnt <= rx_cnt - 32'd1;
      end else begin
        rx_cnt  <= 32'(BIT_CLKS - 1);
        rx_bitn <= rx_bitn + 4'd1;
        if (rx_bitn == 4'd8) begin
          rx_busy <= 1'b0;
          rx_done <= rx_s2;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_perf_uart.sv
// Scoreboard bench: two configurations, expected report bytes queued on stimulus, checked on UART decode.
module tb_axi_mem_perf_uart;

  localparam int BIT0 = 1;
  localparam int BIT1 = 3;
  localparam logic [31:0] W0 = 32'(16 * (16 + 2));
  localparam logic [31:0] R0 = 32'(16 * (16 + 1));
  localparam logic [31:0] W1 = 32'(4 * (1 + 2));
  localparam logic [31:0] R1 = 32'(4 * (1 + 1));
`ifdef AXI_MEM_PERF_ERR_INJECT_EN
  localparam logic [15:0] EXP_E = 16'h0001;
`else
  localparam logic [15:0] EXP_E = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst;
  logic utx0, utx1, urx0, urx1;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  axi_mem_perf_uart #(.CLOCK_FREQ(100), .BAUD_RATE(100)) u_dut0 (
    .clk(clk), .rst(rst), .utx_pin(utx0), .urx_pin(urx0));

  axi_mem_perf_uart #(.CLOCK_FREQ(300), .BAUD_RATE(100), .BURST_LEN(1), .NUM_BURSTS(4)) u_dut1 (
    .clk(clk), .rst(rst), .utx_pin(utx1), .urx_pin(urx1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'b0, n};
    return 8'h41 + {4'b0, n} - 8'd10;
  endfunction

  function automatic logic line_of(input int which);
    return (which == 0) ? utx0 : utx1;
  endfunction

  task automatic push_line(input int which, input logic [31:0] w, input logic [31:0] r,
                           input logic [15:0] e);
    logic [7:0] s[$];
    s.push_back("W"); s.push_back("=");
    for (int i = 7; i >= 0; i--) s.push_back(hexc(w[4*i +: 4]));
    s.push_back(" "); s.push_back("R"); s.push_back("=");
    for (int i = 7; i >= 0; i--) s.push_back(hexc(r[4*i +: 4]));
    s.push_back(" "); s.push_back("E"); s.push_back("=");
    for (int i = 3; i >= 0; i--) s.push_back(hexc(e[4*i +: 4]));
    s.push_back(8'h0D); s.push_back(8'h0A);
    foreach (s[i]) begin
      if (which == 0) q0.push_back(s[i]);
      else            q1.push_back(s[i]);
    end
  endtask

  // Called after one start-bit sample; every bit must hold for exactly bc samples
  task automatic get_frame(input int which, output logic [7:0] b, output logic ok);
    int bc;
    logic v, first;
    bc = (which == 0) ? BIT0 : BIT1;
    ok = 1'b1;
    b = '0;
    first = 1'b0;
    for (int k = 1; k < bc; k++) begin
      @(negedge clk);
      if (line_of(which) !== 1'b0) ok = 1'b0;
    end
    for (int bi = 0; bi < 9; bi++) begin
      for (int k = 0; k < bc; k++) begin
        @(negedge clk);
        v = line_of(which);
        if (k == 0) first = v;
        else if (v !== first) ok = 1'b0;
      end
      if (bi < 8) b[bi] = first;
      else if (first !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic monitor(input int which);
    logic [7:0] b, e;
    logic ok;
    forever begin
      @(negedge clk);
      if (line_of(which) === 1'b0) begin
        forever begin
          get_frame(which, b, ok);
          chk($sformatf("frame%0d", which), 32'(ok), 32'd1);
          if ((which == 0 ? q0.size() : q1.size()) == 0) begin
            chk($sformatf("extra_byte%0d", which), {24'b0, b}, 32'h100);
          end else begin
            e = (which == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("byte%0d", which), {24'b0, b}, {24'b0, e});
          end
          if (b == 8'h0A) break;
          @(negedge clk);
          chk($sformatf("no_gap%0d", which), 32'(line_of(which)), 32'd0);
          if (line_of(which) !== 1'b0) break;
        end
      end
    end
  endtask

  task automatic send_byte(input int which, input logic [7:0] d);
    logic [9:0] fr;
    int bc;
    fr = {1'b1, d, 1'b0};
    bc = (which == 0) ? BIT0 : BIT1;
    for (int i = 0; i < 10; i++) begin
      if (which == 0) urx0 = fr[i];
      else            urx1 = fr[i];
      repeat (bc) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic check_idle(input int cycles);
    int lows;
    lows = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (utx0 !== 1'b1 || utx1 !== 1'b1) lows++;
    end
    chk("idle_high", 32'(lows), 32'd0);
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; urx0 = 1'b1; urx1 = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_utx0", 32'(utx0), 32'd1);
    chk("rst_utx1", 32'(utx1), 32'd1);
    push_line(0, W0, R0, EXP_E);
    push_line(1, W1, R1, EXP_E);
    rst = 1'b0;
    wait_drain(4000);
    check_idle(100);

    // Rerun on a received byte; the trailing byte lands outside DONE and must not add a report
    push_line(0, W0, R0, EXP_E);
    push_line(1, W1, R1, EXP_E);
    fork
      begin send_byte(0, 8'h55); send_byte(0, 8'h33); end
      begin send_byte(1, 8'h55); send_byte(1, 8'h33); end
    join
    wait_drain(4000);
    check_idle(300);

    // Reset in the middle of the read phase of configuration 0
    send_byte(0, 8'hA5);
    repeat (330) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_utx0", 32'(utx0), 32'd1);
    chk("midrst_utx1", 32'(utx1), 32'd1);
    push_line(0, W0, R0, EXP_E);
    push_line(1, W1, R1, EXP_E);
    rst = 1'b0;
    wait_drain(4000);
    check_idle(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
